// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//   Initiator side of the instruction-memory read path. Owns the PC, drives it
//   as the byte address into a combinational instruction memory, and captures
//   {word, pc} into a small FIFO. Decode drains the FIFO over valid/ready.
//   Execute may redirect the PC. A misaligned redirect target parks the unit
//   in HALT with a sticky fault until reset.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous active-high reset
//   imem_addr_o    byte address to instruction memory (always the PC)
//   imem_data_i    instruction word for imem_addr_o, same cycle
//   redirect_i     load redirect_pc_i into the PC this cycle
//   redirect_pc_i  redirect target byte address
//   inst_o         instruction at FIFO head (0 when not valid)
//   pc_o           PC of instruction at FIFO head (0 when not valid)
//   valid_o        FIFO head valid
//   ready_i        decode accepts the head this cycle
//   fault_o        misaligned redirect seen; sticky until reset
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    FIFO_DEPTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  output logic [DATA_WIDTH-1:0] imem_addr_o,
  input  logic [DATA_WIDTH-1:0] imem_data_i,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic [DATA_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  fault_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_HALT  = 1'b1
  } state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [DATA_WIDTH-1:0] pc;
  } entry_t;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  fault_q, fault_d;
  entry_t                buf_q [FIFO_DEPTH];
  entry_t                head;

  logic empty, full, pop, enq, misalign, fifo_vld;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CNT_W'(FIFO_DEPTH));
  // FIFO is flushed on entry to HALT, but gate on state anyway so HALT is
  // unconditionally silent towards decode.
  assign fifo_vld = (state_q == S_FETCH) && !empty;
  assign pop      = fifo_vld && ready_i;
  assign misalign = |redirect_pc_i[1:0];

  // Next-state / datapath control
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    fault_d  = fault_q;
    enq      = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (redirect_i) begin
          // Flush wins over enqueue; a concurrent pop is still taken by
          // decode but has no effect on the (now empty) FIFO.
          rd_ptr_d = '0;
          wr_ptr_d = '0;
          cnt_d    = '0;
          if (misalign) begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end else begin
            pc_d = redirect_pc_i;
          end
        end else begin
          // Full FIFO may still accept when the head leaves this same edge.
          enq = !full || pop;
          if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            pc_d     = pc_q + DATA_WIDTH'(4);
          end
          if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
          cnt_d = cnt_q + CNT_W'(enq) - CNT_W'(pop);
        end
      end
      S_HALT: begin
        // Only reset leaves HALT.
      end
      default: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_VECTOR;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      fault_q  <= fault_d;
    end
  end

  // Entry storage: no reset needed, occupancy count decides visibility.
  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_ent
    always_ff @(posedge clk_i) begin
      if (!reset_i && enq && (wr_ptr_q == PTR_W'(g))) begin
        buf_q[g] <= '{inst: imem_data_i, pc: pc_q};
      end
    end
  end

  assign head        = buf_q[rd_ptr_q];
  assign imem_addr_o = pc_q;
  assign valid_o     = fifo_vld;
  // Zero the head fields when nothing is valid so stale entries never leak.
  assign inst_o      = fifo_vld ? head.inst : '0;
  assign pc_o        = fifo_vld ? head.pc   : '0;
  assign fault_o     = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk;
  logic        reset_i, redirect_i, ready_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] imem_addr_o, imem_data_i, inst_o, pc_o;
  logic        valid_o, fault_o;

  // second instance for PC wrap-around from a high reset vector
  logic        rst_w, redir_w, rdy_w;
  logic [31:0] rpc_w, addr_w, data_w, inst_w, pc_w;
  logic        valid_w, fault_w;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  assign imem_data_i = mem_word(imem_addr_o);
  assign data_w      = mem_word(addr_w);

  instruction_fetch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(32'h0), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .reset_i(reset_i), .imem_addr_o(imem_addr_o), .imem_data_i(imem_data_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .inst_o(inst_o), .pc_o(pc_o),
    .valid_o(valid_o), .ready_i(ready_i), .fault_o(fault_o)
  );

  instruction_fetch_unit #(.DATA_WIDTH(32), .RESET_VECTOR(32'hFFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
    .clk_i(clk), .reset_i(rst_w), .imem_addr_o(addr_w), .imem_data_i(data_w),
    .redirect_i(redir_w), .redirect_pc_i(rpc_w), .inst_o(inst_w), .pc_o(pc_w),
    .valid_o(valid_w), .ready_i(rdy_w), .fault_o(fault_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model: queue of delivered-to-be entries -------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_pc;
  bit          m_halt, m_fault, m_init;

  function automatic bit m_valid();
    return !m_halt && (m_q.size() > 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic m_edge(input bit rst, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit pop;
    ent_t e;
    if (rst) begin
      m_pc = 32'h0; m_q.delete(); m_halt = 0; m_fault = 0; m_init = 1;
    end else if (m_init && !m_halt) begin
      pop = m_valid() && rdy;
      if (rd) begin
        m_q.delete();
        if (rpc[1:0] != 2'b00) begin m_halt = 1; m_fault = 1; end
        else m_pc = rpc;
      end else begin
        if (pop) void'(m_q.pop_front());
        if (m_q.size() < DEPTH) begin
          e.pc = m_pc; e.inst = mem_word(m_pc);
          m_q.push_back(e);
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask

  // One cycle: drive inputs, compare outputs to model, clock, update model.
  task automatic step(input bit rst, input bit rd, input logic [31:0] rpc, input bit rdy);
    reset_i = rst; redirect_i = rd; redirect_pc_i = rpc; ready_i = rdy;
    #1;
    if (m_init) begin
      chk("valid", 32'(valid_o), 32'(m_valid()));
      chk("imem_addr", imem_addr_o, m_pc);
      chk("fault", 32'(fault_o), 32'(m_fault));
      if (m_valid()) begin
        chk("pc", pc_o, m_q[0].pc);
        chk("inst", inst_o, m_q[0].inst);
      end
    end
    @(posedge clk);
    m_edge(rst, rd, rpc, rdy);
    #1;
  endtask

  initial begin
    bit found;
    bit rst, rd, rdy;
    logic [31:0] rpc;
    logic [31:0] exp_pc;
    m_init = 0; m_halt = 0; m_fault = 0; m_pc = 0;
    reset_i = 1; redirect_i = 0; redirect_pc_i = 0; ready_i = 0;
    rst_w = 1; redir_w = 0; rpc_w = 0; rdy_w = 1;
    @(posedge clk); #1;

    // 1. reset then free-run
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_pc", pc_o, 32'd0);
    chk("rst_addr", imem_addr_o, 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // 2. backpressure from a fresh start, then release
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
    chk("stall_addr", imem_addr_o, 32'h8);
    chk("stall_pc", pc_o, 32'h0);
    // 3. release until head is pc 8, then redirect to 0x40
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m_valid() && m_q[0].pc == 32'h8) found = 1;
      else step(0, 0, 0, 1);
    end
    chk("reach_pc8", 32'(found), 32'd1);
    chk("head_pc8", pc_o, 32'h8);
    step(0, 1, 32'h40, 1);
    chk("redir_valid", 32'(valid_o), 32'd0);
    chk("redir_addr", imem_addr_o, 32'h40);
    step(0, 0, 0, 1);
    chk("redir_pc", pc_o, 32'h40);
    chk("redir_inst", inst_o, 32'h1000_0010);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);

    // 4. misaligned redirect, then poke inputs while halted
    step(0, 1, 32'h42, 1);
    chk("mis_fault", 32'(fault_o), 32'd1);
    chk("mis_valid", 32'(valid_o), 32'd0);
    for (int i = 0; i < 6; i++) step(0, i[0], 32'h100, i[1]);
    chk("halt_fault", 32'(fault_o), 32'd1);
    step(1, 0, 0, 1);
    chk("clr_fault", 32'(fault_o), 32'd0);
    chk("clr_addr", imem_addr_o, 32'd0);

    // 5. reset while full, stalled and redirecting
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 1, 32'h80, 0);
    chk("rmid_valid", 32'(valid_o), 32'd0);
    chk("rmid_addr", imem_addr_o, 32'd0);
    chk("rmid_fault", 32'(fault_o), 32'd0);

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 49) == 0) || (m_halt && $urandom_range(0, 7) == 0);
      rd  = ($urandom_range(0, 7) == 0);
      rpc = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 15) == 0) rpc[1:0] = 2'($urandom_range(1, 3));
      rdy = ($urandom_range(0, 2) != 0);
      step(rst, rd, rpc, rdy);
    end

    // 6. wrap-around on the high-reset-vector instance
    rst_w = 1;
    @(posedge clk); @(posedge clk); #1;
    rst_w = 0;
    chk("wrap_rst_valid", 32'(valid_w), 32'd0);
    chk("wrap_rst_addr", addr_w, 32'hFFFF_FFF8);
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("wrap_valid", 32'(valid_w), 32'd1);
      chk("wrap_pc", pc_w, exp_pc);
      chk("wrap_inst", inst_w, mem_word(exp_pc));
      exp_pc = exp_pc + 32'd4;
    end
    chk("wrap_fault", 32'(fault_w), 32'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
